// File: rtl/joojump_pio_led_ctrl.sv
// rtl/joojump_pio_led_ctrl.sv - Avalon-MM LED/PIO port with atomic set/clear, per-bit blink and PWM dimming
module joojump_pio_led_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 50000,
    parameter int PERIOD_W = 16,
    parameter int PWM_BITS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_MODE   = 3'd1;
    localparam logic [2:0] A_OUTSET = 3'd2;
    localparam logic [2:0] A_OUTCLR = 3'd3;
    localparam logic [2:0] A_PERIOD = 3'd4;
    localparam logic [2:0] A_DUTY   = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    blink_en;
    logic [PERIOD_W-1:0] period;
    logic [PWM_BITS-1:0] duty;
    logic                phase;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PERIOD_W-1:0] blk_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic wr;
    logic tick;
    logic pwm_on;
    logic unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign tick         = (pre_cnt == PRE_MAX);
    assign pwm_on       = (&duty) | (pwm_cnt < duty);
    assign unused_wdata = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= '0;
            blink_en <= '0;
            period   <= '0;
            duty     <= '1;
            phase    <= 1'b1;
            pre_cnt  <= '0;
            blk_cnt  <= '0;
            pwm_cnt  <= '0;
            out_port <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;

            if (wr) begin
                case (address)
                    A_DATA:   data     <= writedata[WIDTH-1:0];
                    A_MODE:   blink_en <= writedata[WIDTH-1:0];
                    A_OUTSET: data     <= data | writedata[WIDTH-1:0];
                    A_OUTCLR: data     <= data & ~writedata[WIDTH-1:0];
                    A_PERIOD: period   <= writedata[PERIOD_W-1:0];
                    A_DUTY:   duty     <= writedata[PWM_BITS-1:0];
                    default:  ;
                endcase
            end

            // A PERIOD write restarts the blink cycle and wins over a coincident tick
            if (wr && address == A_PERIOD) begin
                blk_cnt <= '0;
                phase   <= 1'b1;
            end else if (period == '0) begin
                blk_cnt <= '0;
                phase   <= 1'b1;
            end else if (tick) begin
                if (blk_cnt == period - 1'b1) begin
                    blk_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    blk_cnt <= blk_cnt + 1'b1;
                end
            end

            out_port <= data & (~blink_en | {WIDTH{phase}}) & {WIDTH{pwm_on}};
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata[WIDTH-1:0]    = data;
            A_MODE:   readdata[WIDTH-1:0]    = blink_en;
            A_PERIOD: readdata[PERIOD_W-1:0] = period;
            A_DUTY:   readdata[PWM_BITS-1:0] = duty;
            A_STATUS: readdata[0]            = phase;
            default:  readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_joojump_pio_led_ctrl.sv
// tb/tb_joojump_pio_led_ctrl.sv - directed self-checking bench for joojump_pio_led_ctrl
module tb_joojump_pio_led_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks = 0;
    int errors = 0;
    int cyc;

    joojump_pio_led_ctrl #(
        .WIDTH(8), .PRESCALE(4), .PERIOD_W(16), .PWM_BITS(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    // mirrors the prescaler position: at a negedge, cyc % 4 equals pre_cnt
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int t[8];
        int ntog, low1, on_cnt, off_cnt, n;
        logic prev;
        bit found;

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        #23;
        check("rst_out", {24'd0, out_port}, 32'h0);
        bus_read(3'd0, rd); check("rst_data", rd, 32'h0);
        bus_read(3'd5, rd); check("rst_duty", rd, 32'hF);
        bus_read(3'd6, rd); check("rst_status", rd, 32'h1);
        bus_read(3'd4, rd); check("rst_period", rd, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: DATA write latency and readback
        bus_write(3'd0, 32'hA5);
        check("t1_out_at_edge", {24'd0, out_port}, 32'h0);
        @(negedge clk);
        check("t1_out_next", {24'd0, out_port}, 32'hA5);
        bus_read(3'd0, rd); check("t1_read_data", rd, 32'hA5);

        // 2: atomic set/clear
        bus_write(3'd0, 32'h0F);
        bus_write(3'd2, 32'h30);
        @(negedge clk); check("t2_outset", {24'd0, out_port}, 32'h3F);
        bus_write(3'd3, 32'h05);
        @(negedge clk); check("t2_outclr", {24'd0, out_port}, 32'h3A);
        bus_read(3'd0, rd); check("t2_read_data", rd, 32'h3A);
        bus_read(3'd2, rd); check("t2_read_outset", rd, 32'h0);
        bus_read(3'd3, rd); check("t2_read_outclr", rd, 32'h0);
        bus_read(3'd7, rd); check("t2_read_addr7", rd, 32'h0);

        // 3: blink with half-period 3 ticks of 4 clks
        bus_write(3'd0, 32'h03);
        bus_write(3'd1, 32'h01);
        bus_write(3'd4, 32'h03);
        bus_read(3'd4, rd); check("t3_read_period", rd, 32'h3);
        address = 3'd6;
        ntog = 0; low1 = 0; prev = out_port[0];
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!out_port[1]) low1++;
            if (out_port[0] != prev) begin
                if (ntog < 8) t[ntog] = i;
                ntog++;
                check("t3_status_tracks", {31'd0, readdata[0]}, {31'd0, out_port[0]});
                prev = out_port[0];
            end
        end
        check("t3_bit1_steady", low1, 0);
        check("t3_toggle_count", {31'd0, ntog >= 4}, 32'h1);
        if (ntog >= 4) begin
            check("t3_interval_a", t[2] - t[1], 12);
            check("t3_interval_b", t[3] - t[2], 12);
        end

        // 4: PWM dimming
        bus_write(3'd1, 32'h00);
        bus_write(3'd0, 32'hFF);
        bus_write(3'd5, 32'h04);
        @(negedge clk);
        on_cnt = 0; off_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (out_port == 8'hFF) on_cnt++;
            if (out_port == 8'h00) off_cnt++;
        end
        check("t4_duty4_on", on_cnt, 8);
        check("t4_duty4_off", off_cnt, 24);
        bus_write(3'd5, 32'h00);
        @(negedge clk);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (out_port != 8'h00) on_cnt++;
        end
        check("t4_duty0", on_cnt, 0);
        bus_write(3'd5, 32'h1F);
        bus_read(3'd5, rd); check("t4_duty_trunc", rd, 32'hF);
        @(negedge clk);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (out_port == 8'hFF) on_cnt++;
        end
        check("t4_duty15", on_cnt, 16);

        // 5: PERIOD write on a tick edge during phase 0
        bus_write(3'd0, 32'h01);
        bus_write(3'd1, 32'h01);
        bus_write(3'd4, 32'h02);
        address = 3'd6; found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (readdata[0] == 1'b0 && (cyc % 4) == 3) found = 1'b1;
        end
        check("t5_align", {31'd0, found}, 32'h1);
        address = 3'd4; writedata = 32'h5; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 3'd6;
        check("t5_phase_reset", {31'd0, readdata[0]}, 32'h1);
        n = 0; found = 1'b0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (readdata[0] == 1'b0) begin found = 1'b1; n = i; end
        end
        check("t5_first_toggle", n, 20);
        bus_write(3'd4, 32'h0);
        low1 = 0;
        address = 3'd6;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!out_port[0] || !readdata[0]) low1++;
        end
        check("t5_period0_held_on", low1, 0);

        // 6: asynchronous reset mid-blink/PWM
        bus_write(3'd0, 32'hFF);
        bus_write(3'd1, 32'h0F);
        bus_write(3'd4, 32'h1);
        bus_write(3'd5, 32'h4);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (out_port != 8'h00) found = 1'b1;
        end
        check("t6_out_active", {31'd0, found}, 32'h1);
        #3 reset_n = 1'b0;
        #1 check("t6_async_out", {24'd0, out_port}, 32'h0);
        bus_read(3'd0, rd); check("t6_data", rd, 32'h0);
        bus_read(3'd1, rd); check("t6_mode", rd, 32'h0);
        bus_read(3'd4, rd); check("t6_period", rd, 32'h0);
        bus_read(3'd5, rd); check("t6_duty", rd, 32'hF);
        bus_read(3'd6, rd); check("t6_status", rd, 32'h1);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_out_after", {24'd0, out_port}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
